cmos_dvp_pattern_gen: RTL and testbench
=======================================

Name: cmos_dvp_pattern_gen

Overview:
- Synthesizable OV7725-style DVP source, the transmit end of the camera capture path.
- Emits cam_vsync, cam_href and cam_data bytes (RGB565, high byte first) from a deterministic test pattern.
- Replaces the physical sensor in simulation and on-board bring-up, so the capture -> SDRAM -> VGA chain can be exercised without a camera.
- Outputs connect directly to the capture block's cam_vsync, cam_href and cam_data inputs; clk is routed as cam_pclk.

Parameters:
- H_PIXEL, 640: active pixels per line; each pixel takes 2 byte cycles.
- V_PIXEL, 480: active lines per frame.
- H_BLANK, 144: cycles per line with href low after the active bytes.
- VSYNC_LEN, 4: lines with vsync high at frame start.
- V_BACK, 18: blank lines after vsync, before the first active line.
- V_FRONT, 8: blank lines after the last active line.

Ports:
- clk, input, 1: byte clock (acts as cam_pclk).
- rst_n, input, 1: reset.
- gen_en, input, 1: run enable.
- pattern_sel, input, 2: 0 colour bars, 1 gradient, 2 frame-relative counter, 3 solid.
- solid_color, input, 16: RGB565 value for pattern 3.
- cam_vsync, output, 1: frame sync, active high.
- cam_href, output, 1: line valid, active high.
- cam_data, output, 8: pixel byte.
- frame_done, output, 1: one-cycle pulse at end of frame.
- frame_cnt, output, 8: completed frames, wraps.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values: cam_vsync=0, cam_href=0, cam_data=0, frame_done=0, frame_cnt=0; FSM in IDLE; all counters 0.
- Asserting rst_n low mid-frame forces all outputs to reset values immediately, with no frame completion.
- Timing:
  - LINE_LEN = 2*H_PIXEL + H_BLANK cycles.
  - Frame = (VSYNC_LEN + V_BACK + V_PIXEL + V_FRONT) lines.
  - col_cnt counts 0..LINE_LEN-1; line_cnt counts lines within the current state.
- FSM states: IDLE, VSYNC, VBACK, ACTIVE, VFRONT.
- IDLE:
  - Outputs low.
  - When gen_en=1, next cycle enters VSYNC with col_cnt=0.
  - pattern_sel and solid_color are latched on this transition.
- VSYNC: cam_vsync=1 for exactly VSYNC_LEN*LINE_LEN cycles, then VBACK.
- VBACK: V_BACK lines with all outputs low, then ACTIVE.
- ACTIVE, per line:
  - cam_href=1 while col_cnt < 2*H_PIXEL; x = col_cnt>>1; y = active line index.
  - Even col_cnt drives pix[15:8]; odd col_cnt drives pix[7:0].
  - cam_data=0 whenever href=0.
  - After V_PIXEL lines, go to VFRONT.
- VFRONT: V_FRONT blank lines.
  - On the last cycle: frame_done=1 for one cycle and frame_cnt increments (wrapping 255->0).
  - If gen_en=1: go to VSYNC (back-to-back, no gap) and re-latch pattern_sel/solid_color.
  - Otherwise go to IDLE.
- gen_en deasserted mid-frame does not truncate the frame; it is sampled only at frame end.
- Patterns (pix is 16 bits):
  - 0, colour bars: 8 bars of width H_PIXEL/8, bar index = x*8/H_PIXEL (integer). Colours in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - 1, gradient: pix = {x[4:0], y[5:0], x[4:0]}.
  - 2, counter: 16-bit counter, 0 at frame start, +1 per pixel (after each low byte), wraps at FFFF.
  - 3, solid: latched solid_color.
- Output registers: all outputs are registered. cam_vsync, cam_href and cam_data change on the same edge; href and data are aligned.
- Parameter constraint: H_PIXEL must be a multiple of 8 for pattern 0.

Test Plan:
Bench parameters for all scenarios: H_PIXEL=8, V_PIXEL=4, H_BLANK=4, VSYNC_LEN=1, V_BACK=1, V_FRONT=1, giving LINE_LEN=20 and frame=140 cycles.
- Timing: gen_en=1 held, pattern 3, solid_color=A55A.
  - vsync high 20 cycles.
  - 20 low cycles, then 4 lines each with href high 16 cycles and low 4.
  - Then 20 blank cycles; frame_done pulses at cycle 140 after VSYNC entry.
  - Next vsync rises the following cycle.
- Byte order: pattern 3, A55A -> every active line carries bytes A5,5A repeated 8 times; cam_data=00 outside href.
- Colour bars: pattern 0 -> line 0 byte pairs FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000; identical on all 4 lines.
- Counter: pattern 2 -> pixels 0000..001F across the frame (32 pixels); restart at 0000 on the next frame; frame_cnt=1 after the first frame_done.
- Enable/selection:
  - Drop gen_en at mid-line 2 -> frame completes, FSM goes to IDLE, outputs stay low.
  - Change pattern_sel mid-frame -> takes effect only at the next frame.
- Reset mid-operation: rst_n low during ACTIVE -> href, data and vsync go to 0 asynchronously; frame_cnt=0; after release with gen_en=1, the first frame starts from VSYNC.

Source files
------------

// File: rtl/cmos_dvp_pattern_gen_if.sv
// ============================================================================
// Module   : cmos_dvp_pattern_gen_if
// Brief    : DVP camera bus (vsync, href, data byte) between source and capture.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cmos_dvp_pattern_gen_if;
    logic       cam_vsync;
    logic       cam_href;
    logic [7:0] cam_data;

    modport master (
        output cam_vsync,
        output cam_href,
        output cam_data
    );

    modport slave (
        input  cam_vsync,
        input  cam_href,
        input  cam_data
    );
endinterface

`default_nettype wire

// File: rtl/cmos_dvp_pattern_gen.sv
// ============================================================================
// Module   : cmos_dvp_pattern_gen
// Brief    : OV7725-style DVP test-pattern source, RGB565 high byte first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cmos_dvp_pattern_gen #(
    parameter int H_PIXEL   = 640,
    parameter int V_PIXEL   = 480,
    parameter int H_BLANK   = 144,
    parameter int VSYNC_LEN = 4,
    parameter int V_BACK    = 18,
    parameter int V_FRONT   = 8
) (
    input  wire                    clk,
    input  wire                    rst_n,
    input  wire                    gen_en,
    input  wire  [1:0]             pattern_sel,
    input  wire  [15:0]            solid_color,
    cmos_dvp_pattern_gen_if.master dvp,
    output logic                   frame_done,
    output logic [7:0]             frame_cnt
);

    localparam int c_LINE_LEN = 2 * H_PIXEL + H_BLANK;
    localparam int c_COL_W    = $clog2(c_LINE_LEN);
    localparam int c_LINE_W   = $clog2(VSYNC_LEN + V_BACK + V_PIXEL + V_FRONT);

    localparam logic [c_COL_W-1:0]  c_COL_LAST = c_COL_W'(c_LINE_LEN - 1);
    localparam logic [c_COL_W-1:0]  c_HACT     = c_COL_W'(2 * H_PIXEL);
    localparam logic [c_LINE_W-1:0] c_VS_LAST  = c_LINE_W'(VSYNC_LEN - 1);
    localparam logic [c_LINE_W-1:0] c_VB_LAST  = c_LINE_W'(V_BACK - 1);
    localparam logic [c_LINE_W-1:0] c_ACT_LAST = c_LINE_W'(V_PIXEL - 1);
    localparam logic [c_LINE_W-1:0] c_VF_LAST  = c_LINE_W'(V_FRONT - 1);
    localparam logic [15:0]         c_BAR_W    = 16'(H_PIXEL / 8);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VSYNC  = 3'd1,
        S_VBACK  = 3'd2,
        S_ACTIVE = 3'd3,
        S_VFRONT = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [c_COL_W-1:0]    col_q, col_d;
    logic [c_LINE_W-1:0]   line_q, line_d;
    logic [1:0]            sel_q, sel_d;
    logic [15:0]           solid_q, solid_d;
    logic [15:0]           pix_cnt_q, pix_cnt_d;
    logic                  vsync_q, vsync_d;
    logic                  href_q, href_d;
    logic [7:0]            data_q, data_d;
    logic                  frame_done_q, frame_done_d;
    logic [7:0]            frame_cnt_q, frame_cnt_d;

    logic [c_LINE_W-1:0]   w_line_last;
    logic                  w_frame_start;
    logic [15:0]           w_x;
    logic [5:0]            w_y;
    logic [2:0]            w_bar;
    logic [15:0]           w_pix;
    logic [15:0]           w_bar_color;

    always_comb begin
        case (state_q)
            S_VSYNC:  w_line_last = c_VS_LAST;
            S_VBACK:  w_line_last = c_VB_LAST;
            S_ACTIVE: w_line_last = c_ACT_LAST;
            default:  w_line_last = c_VF_LAST;
        endcase
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        line_d  = line_q;
        if (state_q == S_IDLE) begin
            if (gen_en) begin
                state_d = S_VSYNC;
                col_d   = '0;
                line_d  = '0;
            end
        end else if (col_q != c_COL_LAST) begin
            col_d = col_q + 1'b1;
        end else begin
            col_d = '0;
            if (line_q != w_line_last) begin
                line_d = line_q + 1'b1;
            end else begin
                line_d = '0;
                case (state_q)
                    S_VSYNC:  state_d = S_VBACK;
                    S_VBACK:  state_d = S_ACTIVE;
                    S_ACTIVE: state_d = S_VFRONT;
                    // gen_en only matters here, so a frame is never cut short
                    S_VFRONT: state_d = gen_en ? S_VSYNC : S_IDLE;
                    default:  state_d = S_IDLE;
                endcase
            end
        end
    end

    // Outputs are derived from the next-state view so the registered bus lines
    // up exactly with the state the counters are in.
    always_comb begin
        w_frame_start = (state_d == S_VSYNC) && (state_q != S_VSYNC);
        sel_d         = w_frame_start ? pattern_sel : sel_q;
        solid_d       = w_frame_start ? solid_color : solid_q;

        w_x   = 16'(col_d >> 1);
        w_y   = 6'(line_d);
        w_bar = 3'(w_x / c_BAR_W);

        case (w_bar)
            3'd0:    w_bar_color = 16'hFFFF;
            3'd1:    w_bar_color = 16'hFFE0;
            3'd2:    w_bar_color = 16'h07FF;
            3'd3:    w_bar_color = 16'h07E0;
            3'd4:    w_bar_color = 16'hF81F;
            3'd5:    w_bar_color = 16'hF800;
            3'd6:    w_bar_color = 16'h001F;
            default: w_bar_color = 16'h0000;
        endcase

        case (sel_q)
            2'd0:    w_pix = w_bar_color;
            2'd1:    w_pix = {w_x[4:0], w_y, w_x[4:0]};
            2'd2:    w_pix = pix_cnt_q;
            default: w_pix = solid_q;
        endcase

        vsync_d = (state_d == S_VSYNC);
        href_d  = (state_d == S_ACTIVE) && (col_d < c_HACT);
        data_d  = href_d ? (col_d[0] ? w_pix[7:0] : w_pix[15:8]) : 8'h00;

        if (w_frame_start) begin
            pix_cnt_d = '0;
        end else if (href_d && col_d[0]) begin
            pix_cnt_d = pix_cnt_q + 16'd1;
        end else begin
            pix_cnt_d = pix_cnt_q;
        end

        frame_done_d = (state_d == S_VFRONT) && (line_d == c_VF_LAST) && (col_d == c_COL_LAST);
        frame_cnt_d  = frame_done_d ? frame_cnt_q + 8'd1 : frame_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            col_q        <= '0;
            line_q       <= '0;
            sel_q        <= '0;
            solid_q      <= '0;
            pix_cnt_q    <= '0;
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            data_q       <= 8'h00;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= 8'h00;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            line_q       <= line_d;
            sel_q        <= sel_d;
            solid_q      <= solid_d;
            pix_cnt_q    <= pix_cnt_d;
            vsync_q      <= vsync_d;
            href_q       <= href_d;
            data_q       <= data_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
        end
    end

    assign dvp.cam_vsync = vsync_q;
    assign dvp.cam_href  = href_q;
    assign dvp.cam_data  = data_q;
    assign frame_done    = frame_done_q;
    assign frame_cnt     = frame_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_cmos_dvp_pattern_gen.sv
// ============================================================================
// Module   : tb_cmos_dvp_pattern_gen
// Brief    : Directed self-checking bench for the DVP test-pattern source.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cmos_dvp_pattern_gen;

    localparam int c_H_PIXEL  = 8;
    localparam int c_LINE_LEN = 20;
    localparam int c_FRAME    = 140;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        gen_en;
    logic [1:0]  pattern_sel;
    logic [15:0] solid_color;
    logic        frame_done;
    logic [7:0]  frame_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] bar_tab [0:7];

    cmos_dvp_pattern_gen_if dvp_if ();

    cmos_dvp_pattern_gen #(
        .H_PIXEL   (8),
        .V_PIXEL   (4),
        .H_BLANK   (4),
        .VSYNC_LEN (1),
        .V_BACK    (1),
        .V_FRONT   (1)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .gen_en      (gen_en),
        .pattern_sel (pattern_sel),
        .solid_color (solid_color),
        .dvp         (dvp_if),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_pix(input int pat, input logic [15:0] solid, input int x, input int y);
        logic [15:0] xv;
        logic [15:0] yv;
        xv = 16'(x);
        yv = 16'(y);
        case (pat)
            0:       exp_pix = bar_tab[(x * 8) / c_H_PIXEL];
            1:       exp_pix = {xv[4:0], yv[5:0], xv[4:0]};
            2:       exp_pix = 16'(y * c_H_PIXEL + x);
            default: exp_pix = solid;
        endcase
    endfunction

    // {vsync, href, data, frame_done, frame_cnt} for cycle c of a frame
    function automatic logic [18:0] exp_cycle(input int pat, input logic [15:0] solid, input int fc, input int c);
        int          line;
        int          col;
        logic        vs;
        logic        hr;
        logic [7:0]  dat;
        logic        fd;
        logic [7:0]  cnt;
        logic [15:0] pix;
        line = c / c_LINE_LEN;
        col  = c % c_LINE_LEN;
        vs   = (line == 0);
        hr   = (line >= 2) && (line <= 5) && (col < 2 * c_H_PIXEL);
        dat  = 8'h00;
        if (hr) begin
            pix = exp_pix(pat, solid, col / 2, line - 2);
            dat = (col % 2 == 0) ? pix[15:8] : pix[7:0];
        end
        fd  = (c == c_FRAME - 1);
        cnt = fd ? 8'(fc + 1) : 8'(fc);
        exp_cycle = {vs, hr, dat, fd, cnt};
    endfunction

    function automatic logic [31:0] observed();
        observed = {13'd0, dvp_if.cam_vsync, dvp_if.cam_href, dvp_if.cam_data, frame_done, frame_cnt};
    endfunction

    task automatic run_frame(input int fno, input int pat, input logic [15:0] solid, input int fc,
                             input int ncyc, input int chg_at, input logic [1:0] nsel,
                             input logic [15:0] nsolid, input logic nen);
        for (int c = 0; c < ncyc; c++) begin
            tick();
            check($sformatf("frame%0d_cyc%0d", fno, c), observed(), {13'd0, exp_cycle(pat, solid, fc, c)});
            if (c == chg_at) begin
                pattern_sel = nsel;
                solid_color = nsolid;
                gen_en      = nen;
            end
        end
    endtask

    initial begin
        bar_tab[0] = 16'hFFFF; bar_tab[1] = 16'hFFE0; bar_tab[2] = 16'h07FF; bar_tab[3] = 16'h07E0;
        bar_tab[4] = 16'hF81F; bar_tab[5] = 16'hF800; bar_tab[6] = 16'h001F; bar_tab[7] = 16'h0000;

        rst_n       = 1'b0;
        gen_en      = 1'b0;
        pattern_sel = 2'd3;
        solid_color = 16'hA55A;
        repeat (3) tick();
        check("rst_vsync",      {31'd0, dvp_if.cam_vsync}, 32'd0);
        check("rst_href",       {31'd0, dvp_if.cam_href},  32'd0);
        check("rst_data",       {24'd0, dvp_if.cam_data},  32'd0);
        check("rst_frame_done", {31'd0, frame_done},       32'd0);
        check("rst_frame_cnt",  {24'd0, frame_cnt},        32'd0);

        rst_n = 1'b1;
        repeat (2) tick();
        check("idle_no_enable", observed(), 32'd0);

        // solid A55A; mid-line 2 switch to bars and a new solid, effective next frame
        gen_en = 1'b1;
        run_frame(1, 3, 16'hA55A, 0, c_FRAME, 88, 2'd0, 16'h1234, 1'b1);
        run_frame(2, 0, 16'h1234, 1, c_FRAME, 88, 2'd2, 16'h1234, 1'b1);
        run_frame(3, 2, 16'h1234, 2, c_FRAME, -1, 2'd2, 16'h1234, 1'b1);
        run_frame(4, 2, 16'h1234, 3, c_FRAME, 88, 2'd1, 16'h1234, 1'b1);
        // gen_en dropped mid-line 2: frame completes, then idle
        run_frame(5, 1, 16'h1234, 4, c_FRAME, 88, 2'd1, 16'h1234, 1'b0);
        for (int i = 0; i < 30; i++) begin
            tick();
            check($sformatf("idle_after_stop_%0d", i), observed(), 32'h0000_0005);
        end

        // reset in the middle of an active line
        gen_en      = 1'b1;
        pattern_sel = 2'd3;
        solid_color = 16'hBEEF;
        run_frame(6, 3, 16'hBEEF, 5, 51, -1, 2'd3, 16'hBEEF, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_vsync", {31'd0, dvp_if.cam_vsync}, 32'd0);
        check("async_rst_href",  {31'd0, dvp_if.cam_href},  32'd0);
        check("async_rst_data",  {24'd0, dvp_if.cam_data},  32'd0);
        check("async_rst_cnt",   {24'd0, frame_cnt},        32'd0);
        tick();
        check("rst_hold", observed(), 32'd0);
        rst_n = 1'b1;
        run_frame(7, 3, 16'hBEEF, 0, c_FRAME, -1, 2'd3, 16'hBEEF, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
